// File: rtl/trap_arbiter.sv
// Machine-mode trap arbiter: merges the commit-point exception with the standard
// and local interrupts, arbitrates them by fixed priority and produces the CSR trap updates.
module trap_arbiter #(
  parameter int unsigned          PC_LEN    = 32,
  parameter int unsigned          NUM_LOCAL = 16,
  parameter logic [NUM_LOCAL-1:0] EDGE_MASK = '0
) (
  input  logic                    clk,
  input  logic                    rst_sync_n,
  input  logic                    stall_n,
  input  logic                    jump_pending,
  input  logic                    exc_raise,
  input  logic [4:0]              exc_code,
  input  logic [31:0]             exc_tval,
  input  logic [PC_LEN-1:0]       instruction_addr_id_ex,
  input  logic [PC_LEN-1:0]       jump_addr_ex,
  input  logic                    jump_en_ex,
  input  logic                    mstatus_mie,
  input  logic [16+NUM_LOCAL-1:0] mie,
  input  logic                    msip,
  input  logic                    mtip,
  input  logic                    meip,
  input  logic [30:0]             ext_int_code,
  input  logic [NUM_LOCAL-1:0]    local_int,
  input  logic [NUM_LOCAL-1:0]    pend_clr,
  input  logic [29:0]             mtvec_base,
  input  logic [1:0]              mtvec_mode,
  output logic [16+NUM_LOCAL-1:0] mip_out,
  output logic                    int_req,
  output logic                    trap_occurred,
  output logic [31:0]             trap_jump_addr,
  output logic [PC_LEN-1:0]       new_mepc,
  output logic [31:0]             new_mcause,
  output logic [31:0]             new_mtval
);

  typedef enum logic {
    S_IDLE,
    S_ARMED
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_LOCAL-1:0] r_prev;
  logic [NUM_LOCAL-1:0] r_edge_lat;
  logic [PC_LEN-1:0]    r_last_jump;

  logic [NUM_LOCAL-1:0] w_pending;
  logic [NUM_LOCAL-1:0] w_loc_el;
  logic [NUM_LOCAL-1:0] w_win_loc;
  logic [NUM_LOCAL-1:0] w_edge_set;
  logic [NUM_LOCAL-1:0] w_edge_clr;
  logic [NUM_LOCAL-1:0] w_edge_nxt;
  logic                 w_any;
  logic [30:0]          w_code;
  logic                 w_take;
  logic                 w_int_req;
  logic [29:0]          w_vec_base;
  logic                 w_unused_mie;

  assign w_unused_mie = ^{mie[15:12], mie[10:8], mie[6:4], mie[2:0]};

  assign w_pending = (EDGE_MASK & r_edge_lat) | (~EDGE_MASK & local_int);
  assign w_loc_el  = w_pending & mie[16 +: NUM_LOCAL];

  always_comb begin
    mip_out                  = '0;
    mip_out[3]               = msip;
    mip_out[7]               = mtip;
    mip_out[11]              = meip;
    mip_out[16 +: NUM_LOCAL] = w_pending;
  end

  // Lowest priority is applied first so each later match overrides it.
  always_comb begin
    w_code    = '0;
    w_win_loc = '0;
    w_any     = 1'b0;
    for (int unsigned i = 0; i < NUM_LOCAL; i++) begin
      if (w_loc_el[i]) begin
        w_code       = 31'(16 + i);
        w_win_loc    = '0;
        w_win_loc[i] = 1'b1;
        w_any        = 1'b1;
      end
    end
    if (mtip && mie[7]) begin
      w_code    = 31'd7;
      w_win_loc = '0;
      w_any     = 1'b1;
    end
    if (msip && mie[3]) begin
      w_code    = 31'd3;
      w_win_loc = '0;
      w_any     = 1'b1;
    end
    if (meip && mie[11]) begin
      w_code    = ext_int_code;
      w_win_loc = '0;
      w_any     = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_int_req   = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any && mstatus_mie && !exc_raise && stall_n && rst_sync_n) begin
          w_int_req   = 1'b1;
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        // The flush is already committed, so mstatus_mie no longer gates the take.
        if (stall_n) begin
          w_state_nxt = S_IDLE;
          w_take      = !exc_raise && w_any && rst_sync_n;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign int_req       = w_int_req;
  assign trap_occurred = rst_sync_n & (exc_raise | w_take);

  assign w_edge_set = local_int & ~r_prev & EDGE_MASK;
  assign w_edge_clr = pend_clr | (w_take ? w_win_loc : '0);
  assign w_edge_nxt = w_edge_set | (r_edge_lat & ~w_edge_clr & EDGE_MASK);

  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      r_edge_lat  <= '0;
      r_last_jump <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev     <= local_int;
      r_edge_lat <= w_edge_nxt;
      if (stall_n && jump_en_ex) begin
        r_last_jump <= jump_addr_ex;
      end
    end
  end

  assign w_vec_base = mtvec_base + w_code[29:0];

  always_comb begin
    new_mepc = jump_pending ? r_last_jump : instruction_addr_id_ex;
    if (exc_raise) begin
      new_mcause     = {1'b0, 26'b0, exc_code};
      new_mtval      = exc_tval;
      trap_jump_addr = {mtvec_base, 2'b00};
    end else begin
      new_mcause     = {1'b1, w_code};
      new_mtval      = '0;
      trap_jump_addr = (mtvec_mode == 2'b01) ? {w_vec_base, 2'b00} : {mtvec_base, 2'b00};
    end
  end

endmodule

// File: tb/tb_trap_arbiter.sv
// Directed bench for trap_arbiter: level/edge locals, priority, stall, exception preemption,
// withdrawal, jump-target mepc and reset abort, all with hand-computed expectations.
module tb_trap_arbiter;

  localparam int unsigned PC_LEN    = 32;
  localparam int unsigned NUM_LOCAL = 16;

  logic                    clk;
  logic                    rst_sync_n;
  logic                    stall_n;
  logic                    jump_pending;
  logic                    exc_raise;
  logic [4:0]              exc_code;
  logic [31:0]             exc_tval;
  logic [PC_LEN-1:0]       instruction_addr_id_ex;
  logic [PC_LEN-1:0]       jump_addr_ex;
  logic                    jump_en_ex;
  logic                    mstatus_mie;
  logic [16+NUM_LOCAL-1:0] mie;
  logic                    msip, mtip, meip;
  logic [30:0]             ext_int_code;
  logic [NUM_LOCAL-1:0]    local_int;
  logic [NUM_LOCAL-1:0]    pend_clr;
  logic [29:0]             mtvec_base;
  logic [1:0]              mtvec_mode;
  logic [16+NUM_LOCAL-1:0] mip_out;
  logic                    int_req;
  logic                    trap_occurred;
  logic [31:0]             trap_jump_addr;
  logic [PC_LEN-1:0]       new_mepc;
  logic [31:0]             new_mcause;
  logic [31:0]             new_mtval;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  trap_arbiter #(
    .PC_LEN    (PC_LEN),
    .NUM_LOCAL (NUM_LOCAL),
    .EDGE_MASK (16'h0001)
  ) dut (
    .clk                    (clk),
    .rst_sync_n             (rst_sync_n),
    .stall_n                (stall_n),
    .jump_pending           (jump_pending),
    .exc_raise              (exc_raise),
    .exc_code               (exc_code),
    .exc_tval               (exc_tval),
    .instruction_addr_id_ex (instruction_addr_id_ex),
    .jump_addr_ex           (jump_addr_ex),
    .jump_en_ex             (jump_en_ex),
    .mstatus_mie            (mstatus_mie),
    .mie                    (mie),
    .msip                   (msip),
    .mtip                   (mtip),
    .meip                   (meip),
    .ext_int_code           (ext_int_code),
    .local_int              (local_int),
    .pend_clr               (pend_clr),
    .mtvec_base             (mtvec_base),
    .mtvec_mode             (mtvec_mode),
    .mip_out                (mip_out),
    .int_req                (int_req),
    .trap_occurred          (trap_occurred),
    .trap_jump_addr         (trap_jump_addr),
    .new_mepc               (new_mepc),
    .new_mcause             (new_mcause),
    .new_mtval              (new_mtval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst_sync_n = 1'b0; stall_n = 1'b1; jump_pending = 1'b0;
    exc_raise = 1'b0; exc_code = '0; exc_tval = '0;
    instruction_addr_id_ex = 32'h1000; jump_addr_ex = '0; jump_en_ex = 1'b0;
    mstatus_mie = 1'b0; mie = '0; msip = 1'b0; mtip = 1'b0; meip = 1'b0;
    ext_int_code = '0; local_int = '0; pend_clr = '0;
    mtvec_base = '0; mtvec_mode = 2'b00;

    // Reset: outputs forced low even with an eligible level source present
    repeat (2) next_cycle();
    #1;
    check_eq("rst_mip", mip_out, 32'h0);
    local_int = 16'h0004; mie = 32'h0004_0000; mstatus_mie = 1'b1;
    #1;
    check_eq("rst_int_req", {31'b0, int_req}, 32'h0);
    check_eq("rst_trap", {31'b0, trap_occurred}, 32'h0);
    local_int = '0;
    next_cycle(); rst_sync_n = 1'b1;

    // Level LOCAL[2], vectored, base 0x100
    next_cycle();
    local_int = 16'h0004; mie = 32'h0004_0000; mstatus_mie = 1'b1;
    mtvec_mode = 2'b01; mtvec_base = 30'h100;
    #1;
    check_eq("l2_int_req", {31'b0, int_req}, 32'h1);
    check_eq("l2_req_notrap", {31'b0, trap_occurred}, 32'h0);
    check_eq("l2_mip", mip_out, 32'h0004_0000);
    next_cycle(); #1;
    check_eq("l2_trap", {31'b0, trap_occurred}, 32'h1);
    check_eq("l2_armed_noreq", {31'b0, int_req}, 32'h0);
    check_eq("l2_mcause", new_mcause, 32'h8000_0012);
    check_eq("l2_jump", trap_jump_addr, 32'h448);
    check_eq("l2_mtval", new_mtval, 32'h0);
    check_eq("l2_mepc", new_mepc, 32'h1000);
    next_cycle(); local_int = '0;
    #1;
    check_eq("l2_idle", {31'b0, int_req}, 32'h0);

    // MEI beats MSI, direct mode, base 0x200
    next_cycle();
    mie = 32'h0000_0808; meip = 1'b1; msip = 1'b1; ext_int_code = 31'h20;
    mtvec_mode = 2'b00; mtvec_base = 30'h200;
    #1;
    check_eq("mei_int_req", {31'b0, int_req}, 32'h1);
    check_eq("mei_mip", mip_out, 32'h0000_0808);
    next_cycle(); #1;
    check_eq("mei_trap", {31'b0, trap_occurred}, 32'h1);
    check_eq("mei_mcause", new_mcause, 32'h8000_0020);
    check_eq("mei_jump", trap_jump_addr, 32'h800);
    next_cycle(); meip = 1'b0; msip = 1'b0;

    // Edge LOCAL[0]: one-cycle pulse latches, masked by mstatus_mie for now
    next_cycle();
    mstatus_mie = 1'b0; mie = 32'h0001_0000; local_int = 16'h0001;
    next_cycle(); local_int = '0;
    #1;
    check_eq("edge_latched", mip_out, 32'h0001_0000);
    check_eq("edge_mie_gate", {31'b0, int_req}, 32'h0);
    next_cycle(); #1;
    check_eq("edge_held", mip_out, 32'h0001_0000);
    pend_clr = 16'h0001;
    next_cycle(); pend_clr = '0;
    #1;
    check_eq("edge_cleared", mip_out, 32'h0);
    local_int = 16'h0001; pend_clr = 16'h0001;
    next_cycle(); local_int = '0; pend_clr = '0;
    #1;
    check_eq("edge_set_wins", mip_out, 32'h0001_0000);
    mstatus_mie = 1'b1;
    #1;
    check_eq("edge_int_req", {31'b0, int_req}, 32'h1);
    next_cycle(); #1;
    check_eq("edge_trap", {31'b0, trap_occurred}, 32'h1);
    check_eq("edge_mcause", new_mcause, 32'h8000_0010);
    next_cycle(); #1;
    check_eq("edge_after_take", mip_out, 32'h0);
    check_eq("edge_no_rereq", {31'b0, int_req}, 32'h0);

    // Latch a jump target for the later mepc check
    jump_en_ex = 1'b1; jump_addr_ex = 32'h80;
    next_cycle(); jump_en_ex = 1'b0; jump_addr_ex = 32'h44;

    // Armed then stalled 3 cycles
    next_cycle();
    local_int = 16'h0004; mie = 32'h0004_0000; mtvec_mode = 2'b01; mtvec_base = 30'h100;
    #1;
    check_eq("st_int_req", {31'b0, int_req}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); stall_n = 1'b0;
      #1;
      check_eq("st_hold_trap", {31'b0, trap_occurred}, 32'h0);
      check_eq("st_hold_req", {31'b0, int_req}, 32'h0);
    end
    next_cycle(); stall_n = 1'b1; jump_pending = 1'b1;
    #1;
    check_eq("st_trap", {31'b0, trap_occurred}, 32'h1);
    check_eq("st_jump", trap_jump_addr, 32'h448);
    check_eq("st_mepc", new_mepc, 32'h80);
    next_cycle(); jump_pending = 1'b0;
    #1;
    check_eq("ex_rereq", {31'b0, int_req}, 32'h1);

    // Armed then exception preempts the take
    next_cycle(); exc_raise = 1'b1; exc_code = 5'd2; exc_tval = 32'hDEAD;
    #1;
    check_eq("ex_trap", {31'b0, trap_occurred}, 32'h1);
    check_eq("ex_mcause", new_mcause, 32'h2);
    check_eq("ex_mtval", new_mtval, 32'hDEAD);
    check_eq("ex_jump", trap_jump_addr, 32'h400);
    next_cycle(); exc_raise = 1'b0;
    #1;
    check_eq("ex_pending_rereq", {31'b0, int_req}, 32'h1);

    // Armed, level source withdrawn: no trap, back to IDLE
    next_cycle(); local_int = '0;
    #1;
    check_eq("wd_notrap", {31'b0, trap_occurred}, 32'h0);
    next_cycle(); local_int = 16'h0004;
    #1;
    check_eq("wd_idle_rereq", {31'b0, int_req}, 32'h1);

    // Reset while armed aborts the take; level source requests again after
    next_cycle(); rst_sync_n = 1'b0;
    #1;
    check_eq("ra_trap", {31'b0, trap_occurred}, 32'h0);
    check_eq("ra_req", {31'b0, int_req}, 32'h0);
    next_cycle(); rst_sync_n = 1'b1;
    #1;
    check_eq("ra_rereq", {31'b0, int_req}, 32'h1);
    check_eq("ra_notrap", {31'b0, trap_occurred}, 32'h0);
    check_eq("ra_mepc_jump_clr", new_mepc, 32'h1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/trap_arbiter.md
# trap_arbiter

Parametrised machine-mode trap arbiter for the RISC-V core. It sits between the commit point of the ID/EX stage and the CSR file. It merges the synchronous exception from commit with the three standard M-mode interrupts and up to 16 platform-local interrupt lines, each configurable as edge or level sensitive. It arbitrates them by fixed priority and drives mepc/mcause/mtval and the trap target in direct or vectored mode. Interrupt acceptance is a two-phase handshake: request/flush, then take at the next unstalled cycle.

## Interface
- PC_LEN, 32: width of instruction addresses.
- NUM_LOCAL, 16: number of local interrupt lines, legal range 1..16; line i maps to cause code 16+i.
- EDGE_MASK, all zeros: NUM_LOCAL bits; bit i set makes line i rising-edge sensitive, clear makes it level sensitive.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_sync_n  in  1  synchronous reset, active low.
- stall_n  in  1  pipeline advances when high.
- jump_pending  in  1  a taken jump has not yet reached the ID/EX stage.
- exc_raise  in  1  synchronous exception at the commit point.
- exc_code  in  5  exception cause code.
- exc_tval  in  32  trap value for the exception.
- instruction_addr_id_ex  in  PC_LEN  PC of the instruction at commit.
- jump_addr_ex  in  PC_LEN  jump target computed in EX.
- jump_en_ex  in  1  jump taken in EX.
- mstatus_mie  in  1  global interrupt enable.
- mie  in  16+NUM_LOCAL  CSR mie; bits 3, 7, 11 and 16+.
- msip, mtip, meip  in  1 each  standard interrupt pending inputs.
- ext_int_code  in  31  cause code used in place of 11 for an external interrupt.
- local_int  in  NUM_LOCAL  local interrupt lines, synchronous to clk.
- pend_clr  in  NUM_LOCAL  one-cycle clear pulses for edge latches, driven by CSR writes to mip.
- mtvec_base  in  30  mtvec BASE field.
- mtvec_mode  in  2  mtvec MODE field; 01 selects vectored mode.
- mip_out  out  16+NUM_LOCAL  composed mip value for CSR reads.
- int_req  out  1  request to flush the pipeline for an interrupt.
- trap_occurred  out  1  a trap is taken this cycle.
- trap_jump_addr  out  32  trap handler address.
- new_mepc  out  PC_LEN  value to write to mepc.
- new_mcause  out  32  value to write to mcause.
- new_mtval  out  32  value to write to mtval.

## Operation
- Local pending:
  - Level line: pending_i = local_int[i].
  - Edge line: latch set when local_int[i] is 1 and its registered previous value is 0.
  - Edge latch cleared by pend_clr[i], or when line i is taken.
  - If set and clear occur in the same cycle, set wins.
- mip_out:
  - bit 3 = msip, bit 7 = mtip, bit 11 = meip.
  - bits 16+i = pending_i.
  - All other bits 0.
- Eligible sources are those with pending & mie.
- Fixed priority: MEI > MSI > MTI > LOCAL[NUM_LOCAL-1] > … > LOCAL[0].
- Cause code of the winner:
  - MEI → ext_int_code.
  - MSI → 3.
  - MTI → 7.
  - LOCAL[i] → 16+i.
- FSM states IDLE and ARMED:
  - IDLE: int_req = any_eligible & mstatus_mie & !exc_raise & stall_n. If int_req, go to ARMED.
  - ARMED, stall_n low: hold; no outputs change.
  - ARMED, stall_n high and exc_raise: exception trap. Return to IDLE. The interrupt stays pending and its edge latch is not cleared.
  - ARMED, stall_n high, no exception, some source eligible: interrupt trap using the winner re-evaluated in this cycle. Clear that line's edge latch if it is edge sensitive. Return to IDLE.
  - ARMED, stall_n high, nothing eligible: the source was withdrawn. Return to IDLE with no trap.
- The winner in ARMED is taken regardless of mstatus_mie, because the flush was already committed.
- trap_occurred = exc_raise | interrupt take (ARMED case above).
- new_mcause:
  - Exception: {1'b0, 26'b0, exc_code}.
  - Interrupt: {1'b1, code[30:0]}.
- new_mtval: exc_tval for an exception, 0 for an interrupt.
- trap_jump_addr:
  - Exception, or mtvec_mode ≠ 01: {mtvec_base, 2'b00}.
  - Interrupt with mtvec_mode = 01: {mtvec_base + code[29:0], 2'b00}. The sum is 30 bits and wraps modulo 2^30.
- last_jump_addr: register loaded from jump_addr_ex when stall_n & jump_en_ex.
- new_mepc = jump_pending ? last_jump_addr : instruction_addr_id_ex.

## Timing
- Exception: trap_occurred in the same cycle as exc_raise, combinationally. No state change.
- Interrupt:
  - int_req is combinational in cycle t.
  - ARMED from t+1.
  - trap_occurred in the first cycle ≥ t+1 with stall_n high.
  - Minimum latency from eligible to trap is 1 cycle.
- int_req is never asserted in ARMED, so at most one request is outstanding.
- Edge latch visibility: an edge sampled at clock edge k shows in mip_out from cycle k+1.
- Reset (rst_sync_n low at a clock edge):
  - state = IDLE.
  - edge latches, previous-input registers and last_jump_addr = 0.
  - While rst_sync_n is low, int_req and trap_occurred are forced to 0.
  - A reset in ARMED aborts the take; level sources re-request after reset.

## Test plan
- LOCAL[2] level with mie[18] = 1, mstatus_mie = 1, mtvec_mode = 01, base 0x100 → int_req in cycle t; at t+1: trap_occurred = 1, new_mcause = 0x80000012, trap_jump_addr = 0x448.
- meip and msip together, ext_int_code = 0x20, direct mode, base 0x200 → new_mcause = 0x80000020, trap_jump_addr = 0x800.
- Edge LOCAL[0] pulse of 1 cycle → mip_out[16] stays 1 until taken. After the take it is 0. A pend_clr and an edge in the same cycle leave it at 1.
- Armed, then stall_n held low 3 cycles → no trap, state held; take on the first cycle with stall_n high. Armed, then exc_raise code 2 → new_mcause = 0x2, the interrupt remains pending and is requested again.
- Level source dropped while ARMED → return to IDLE, trap_occurred stays 0.
- jump_en_ex with target 0x80 latched, then jump_pending = 1 at the trap → new_mepc = 0x80. rst_sync_n low in ARMED → IDLE, outputs 0.
